count_burst_sequencer: RTL

COUNT_BURST_SEQUENCER -- requirements
Module: count_burst_sequencer

---
 rtl/count_burst_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/count_burst_sequencer.sv
// Burst sequencer driving an external loadable up/down counter; keeps a cycle-exact
// shadow of the counter value and tracks the count steps still to issue.
module count_burst_sequencer #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  RST_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  dir,
    input  logic                  fill,
    input  logic                  stall,
    input  logic                  abort,
    output logic                  SET,
    output logic                  LD_n,
    output logic                  CNT_n,
    output logic                  UP_n,
    output logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] shadow,
    output logic [LEN_WIDTH-1:0]  remaining,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  dir_q, dir_d;
    logic                  fill_q, fill_d;

    // State, capture and shadow registers
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            shadow_q <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            shadow_q <= shadow_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            fill_q   <= fill_d;
        end
    end

    // Next state and counter strobes; strobes are combinational so the external
    // counter and the shadow move on the same edge.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        shadow_d = shadow_q;
        len_d    = len_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        fill_d   = fill_q;
        SET      = 1'b0;
        LD_n     = 1'b1;
        CNT_n    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    len_d   = len;
                    dir_d   = dir;
                    fill_d  = fill;
                    state_d = (len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (fill_q) begin
                        SET      = 1'b1;
                        shadow_d = '1;
                    end else begin
                        LD_n     = 1'b0;
                        shadow_d = base_q;
                    end
                    rem_d   = len_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    CNT_n    = 1'b0;
                    shadow_d = dir_q ? shadow_q - DATA_WIDTH'(1) : shadow_q + DATA_WIDTH'(1);
                    rem_d    = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign UP_n      = dir_q;
    assign D         = base_q;
    assign shadow    = shadow_q;
    assign remaining = rem_q;
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
